// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - XLEN / FETCH_BUF_DEPTH sizing constants and derived widths
//   - default reset PC
//   - fetch FSM state enum
//   - word-alignment helper
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN            = 32;
    localparam int FETCH_BUF_DEPTH = 2;

    // One buffer entry is {pc, instruction}
    localparam int ENTRY_W    = 2 * XLEN;
    localparam int BUF_PTR_W  = $clog2(FETCH_BUF_DEPTH);
    localparam int BUF_CNT_W  = $clog2(FETCH_BUF_DEPTH + 1);

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Force an address onto a 4-byte boundary
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small circular FIFO holding {pc, inst} pairs between the memory response and
// decode.
//   clk_i        clock
//   rst_ni       synchronous active-low reset (clears pointers, count, data)
//   flush_i      drop all entries at the next edge (wins over push/pop)
//   push_i       write push_data_i at the tail
//   push_data_i  {pc, inst}
//   pop_i        remove head entry
//   head_o       current head entry
//   count_o      number of valid entries
//   empty_o      no valid entries
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [ENTRY_W-1:0]   push_data_i,
    input  logic                 pop_i,
    output logic [ENTRY_W-1:0]   head_o,
    output logic [BUF_CNT_W-1:0] count_o,
    output logic                 empty_o
);

    logic [ENTRY_W-1:0]   mem_q [FETCH_BUF_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [FETCH_BUF_DEPTH];
    logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_CNT_W-1:0] count_q, count_d;
    logic                 do_pop_s;
    logic                 do_push_s;

    // Handshake qualification and next-state for pointers, count and storage
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        do_pop_s  = pop_i && (count_q != {BUF_CNT_W{1'b0}});
        // A push into a full buffer is only legal when the head leaves the same cycle
        do_push_s = push_i && ((count_q != BUF_CNT_W'(FETCH_BUF_DEPTH)) || do_pop_s);

        if (flush_i) begin
            wr_ptr_d = {BUF_PTR_W{1'b0}};
            rd_ptr_d = {BUF_PTR_W{1'b0}};
            count_d  = {BUF_CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + BUF_PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + BUF_PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + BUF_CNT_W'(1);
                2'b01:   count_d = count_q - BUF_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= {BUF_PTR_W{1'b0}};
            rd_ptr_q <= {BUF_PTR_W{1'b0}};
            count_q  <= {BUF_CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == {BUF_CNT_W{1'b0}});

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Issues word-aligned fetch requests, captures single-cycle-latency responses
// into a 2-entry buffer and presents them to decode with a valid/ready
// handshake. Redirects flush the buffer and restart fetching at the target.
//   RESET_PC        fetch address after reset (word aligned)
//   clk             clock
//   reset           synchronous active-low reset
//   imem_req_*      request channel to instruction memory (valid/ready, addr)
//   imem_rsp_*      response channel, valid exactly one cycle after acceptance
//   redirect_*      branch/jump redirect from a later stage
//   inst_*          instruction channel to decode (valid/ready, inst, pc)
// -----------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int OCC_W = BUF_CNT_W + 1;
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FETCH_BUF_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [ENTRY_W-1:0]   buf_head_s;
    logic [BUF_CNT_W-1:0] buf_count_s;
    logic                 buf_empty_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 req_s;
    logic                 accept_s;
    logic [OCC_W-1:0]     occ_s;

    // Request / handshake decision and FSM next-state
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;

        // Outputs are forced quiet while reset is held
        inst_valid = reset && !buf_empty_s;
        pop_s      = inst_valid && inst_ready;

        // Slots that will be taken once everything already committed lands
        occ_s = OCC_W'(buf_count_s) + OCC_W'(inflight_q) - OCC_W'(pop_s);

        req_s    = reset && (state_q == ST_RUN) && !redirect_valid && (occ_s < OCC_LIMIT);
        accept_s = req_s && imem_req_ready;

        // Only a response to our own outstanding request is captured; a
        // response during a redirect belongs to the abandoned path
        push_s = imem_rsp_valid && inflight_q && !redirect_valid;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
        end else if (accept_s) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end else begin
            pc_d = pc_q;
        end

        imem_req_valid = req_s;
        imem_req_addr  = req_s ? pc_q : {XLEN{1'b0}};

        if (inst_valid) begin
            inst    = buf_head_s[XLEN-1:0];
            inst_pc = buf_head_s[ENTRY_W-1:XLEN];
        end else begin
            inst    = {XLEN{1'b0}};
            inst_pc = {XLEN{1'b0}};
        end
    end

    // FSM, PC and in-flight tracking registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {XLEN{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk_i       (clk),
        .rst_ni      (reset),
        .flush_i     (redirect_valid),
        .push_i      (push_s),
        .push_data_i ({inflight_pc_q, imem_rsp_data}),
        .pop_i       (pop_s),
        .head_o      (buf_head_s),
        .count_o     (buf_count_s),
        .empty_o     (buf_empty_s)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed scenarios followed by a randomized phase. The bench acts as the
// instruction memory (fixed one-cycle response latency) and keeps a queue
// based reference model of the fetch unit's observable behaviour.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_run         = 1'b0;
    logic [31:0] m_pc          = 32'h0000_0000;
    logic [63:0] m_q[$];
    bit          m_inflight    = 1'b0;
    logic [31:0] m_inflight_pc = 32'h0000_0000;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a scrambled function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic step(input bit rst_n, input bit mem_rdy, input bit redir,
                        input logic [31:0] rpc, input bit dec_rdy, input bit stale);
        bit          e_req;
        bit          e_val;
        bit          e_pop;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] rsp;
        int          occ;

        @(negedge clk);
        reset          = rst_n;
        imem_req_ready = mem_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = dec_rdy;
        rsp            = m_inflight ? mem_word(m_inflight_pc) : 32'hDEAD_BEEF;
        imem_rsp_valid = m_inflight | stale;
        imem_rsp_data  = rsp;
        #1;

        e_req  = 1'b0;
        e_val  = 1'b0;
        e_pop  = 1'b0;
        e_inst = 32'h0000_0000;
        e_pc   = 32'h0000_0000;
        if (rst_n) begin
            e_val = (m_q.size() != 0);
            if (e_val) begin
                e_inst = m_q[0][31:0];
                e_pc   = m_q[0][63:32];
            end
            e_pop = e_val && dec_rdy;
            occ   = m_q.size() + int'(m_inflight) - int'(e_pop);
            e_req = m_run && !redir && (occ < 2);
        end

        chk("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
        if (e_req) chk("imem_req_addr", imem_req_addr, m_pc);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, e_val});
        if (!rst_n || e_val) begin
            chk("inst", inst, e_inst);
            chk("inst_pc", inst_pc, e_pc);
        end

        @(posedge clk);
        if (!rst_n) begin
            m_run      = 1'b0;
            m_pc       = 32'h0000_0000;
            m_q.delete();
            m_inflight = 1'b0;
        end else if (redir) begin
            m_run      = 1'b1;
            m_pc       = {rpc[31:2], 2'b00};
            m_q.delete();
            m_inflight = 1'b0;
        end else begin
            m_run = 1'b1;
            if (e_pop) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back({m_inflight_pc, rsp});
            if (e_req && mem_rdy) begin
                m_inflight    = 1'b1;
                m_inflight_pc = m_pc;
                m_pc          = m_pc + 32'd4;
            end else begin
                m_inflight = 1'b0;
            end
        end
    endtask

    initial begin
        bit prev_rst;

        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        inst_ready     = 1'b0;

        // Reset held: all outputs quiet
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming from RESET_PC with memory and decode always ready
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Decode stalls for 5 cycles, then resumes
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Redirect to an unaligned target while a response is arriving
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Address wrap at the top of the address space
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Memory ready toggling 1,0,1,0
        for (int i = 0; i < 12; i++) step(1'b1, (i % 2) == 0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Single-cycle reset with a request outstanding, then a stale response
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Redirect during the boot cycle
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_2001, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        prev_rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bit r_rst;
            r_rst = ($urandom_range(0, 99) != 0);
            step(r_rst,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom,
                 $urandom_range(0, 3) != 0,
                 prev_rst);
            prev_rst = !r_rst;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
